// File: rtl/core_pkg.sv
// core_pkg: shared widths, reset PC and fetch-queue slot type
package core_pkg;
  localparam int DEF_XLEN = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int INSTR_WIDTH = 32;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic filled;
  } fetch_slot_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode handshake signals
interface fetch_unit_if
  import core_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);
  logic imem_req_valid;
  logic imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic pred_redirect_valid;
  logic [XLEN-1:0] pred_redirect_target;
  logic ex_redirect_valid;
  logic [XLEN-1:0] ex_redirect_target;
  logic if_valid;
  logic if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input imem_req_ready, imem_resp_valid, imem_resp_data, pred_redirect_valid,
    pred_redirect_target, ex_redirect_valid, ex_redirect_target, if_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, pred_redirect_valid,
    pred_redirect_target, ex_redirect_valid, ex_redirect_target, if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order slot ring with separate alloc/fill/head pointers and flush
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  input logic i_flush,
  input logic i_alloc,
  input logic [DEF_XLEN-1:0] i_alloc_pc,
  input logic i_fill,
  input logic [INSTR_WIDTH-1:0] i_fill_instr,
  input logic i_pop,
  output fetch_slot_t o_head,
  output logic [AW:0] o_count,
  output logic [AW:0] o_pend
);
  fetch_slot_t r_slots [DEPTH];
  logic [AW-1:0] r_alloc, r_fill, r_head;
  logic [AW:0] r_count, r_pend;
  assign o_head = r_slots[r_head];
  assign o_count = r_count;
  assign o_pend = r_pend;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
      r_alloc <= '0;
      r_fill <= '0;
      r_head <= '0;
      r_count <= '0;
      r_pend <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i].filled <= 1'b0;
      r_alloc <= '0;
      r_fill <= '0;
      r_head <= '0;
      r_count <= '0;
      r_pend <= '0;
    end else begin
      if (i_alloc) begin
        r_slots[r_alloc].pc <= i_alloc_pc;
        r_slots[r_alloc].filled <= 1'b0;
      end
      if (i_fill) begin
        r_slots[r_fill].instr <= i_fill_instr;
        r_slots[r_fill].filled <= 1'b1;
      end
      if (i_pop) r_slots[r_head].filled <= 1'b0;
      r_alloc <= r_alloc + AW'(i_alloc);
      r_fill <= r_fill + AW'(i_fill);
      r_head <= r_head + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_alloc) - (AW+1)'(i_pop);
      r_pend <= r_pend + (AW+1)'(i_alloc) - (AW+1)'(i_fill);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, in-order imem request issue, redirect priority and stale-response dropping
module fetch_unit
  import core_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int FQ_DEPTH = 4,
  localparam int AW = $clog2(FQ_DEPTH)
) (
  input logic clk,
  input logic reset,
  fetch_unit_if.master bus
);
  logic [XLEN-1:0] r_pc, w_target;
  logic [AW:0] r_drop, w_count, w_pend;
  fetch_slot_t w_head;
  logic w_redirect, w_req_valid, w_fire, w_drop_hit, w_fill, w_pop;
  assign w_redirect = bus.ex_redirect_valid || bus.pred_redirect_valid;
  assign w_target = bus.ex_redirect_valid ? bus.ex_redirect_target : bus.pred_redirect_target;
  // in-flight = live pending + stale; keeping it below FQ_DEPTH bounds drop_count too
  assign w_req_valid = !reset && !w_redirect && (w_count < (AW+1)'(FQ_DEPTH)) &&
                       ((AW+2)'(w_pend) + (AW+2)'(r_drop) < (AW+2)'(FQ_DEPTH));
  assign w_fire = w_req_valid && bus.imem_req_ready;
  assign w_drop_hit = bus.imem_resp_valid && (r_drop != '0);
  assign w_fill = bus.imem_resp_valid && !w_drop_hit;
  assign w_pop = w_head.filled && bus.if_ready;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr = {r_pc[XLEN-1:2], 2'b00};
  assign bus.if_valid = w_head.filled;
  assign bus.if_instr = w_head.instr;
  assign bus.if_pc = w_head.pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pc <= RESET_PC;
      r_drop <= '0;
    end else begin
      r_pc <= w_redirect ? {w_target[XLEN-1:2], 2'b00} : w_fire ? r_pc + XLEN'(4) : r_pc;
      r_drop <= w_redirect ? r_drop + w_pend - (AW+1)'(bus.imem_resp_valid) : r_drop - (AW+1)'(w_drop_hit);
    end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk(clk),
    .reset(reset),
    .i_flush(w_redirect),
    .i_alloc(w_fire),
    .i_alloc_pc({r_pc[XLEN-1:2], 2'b00}),
    .i_fill(w_fill),
    .i_fill_instr(bus.imem_resp_data),
    .i_pop(w_pop),
    .o_head(w_head),
    .o_count(w_count),
    .o_pend(w_pend)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven and random checks against a queue-based fetch model
module tb_fetch_unit;
  import core_pkg::*;
  localparam int D = 4;
  typedef struct {logic [31:0] addr; int ep;} req_t;
  typedef struct {logic exv; logic [31:0] ext; logic pv; logic [31:0] pt; logic [31:0] exp;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  req_t mem_q[$];
  logic [31:0] path_q[$];
  logic [31:0] fires[$];
  logic [31:0] pops[$];
  int filled = 0;
  int epoch = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] last_addr;
  int total = 0;
  int bad = 0;
  vec_t vecs[6];
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'h0;
    bus.if_ready = 1'b0;
    bus.ex_redirect_valid = 1'b0;
    bus.ex_redirect_target = 32'h0;
    bus.pred_redirect_valid = 1'b0;
    bus.pred_redirect_target = 32'h0;
  endtask
  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_if_valid", 32'(bus.if_valid), 32'h0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    mem_q.delete();
    path_q.delete();
    fires.delete();
    pops.delete();
    filled = 0;
    epoch++;
    exp_pc = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic step(input logic rdy, input logic rsp, input logic ifr, input logic exv,
                      input logic [31:0] ext, input logic pv, input logic [31:0] pt);
    logic want_req, fire, pop, redir, do_rsp;
    logic [31:0] tgt;
    req_t r;
    @(negedge clk);
    do_rsp = rsp && (mem_q.size() > 0);
    bus.imem_req_ready = rdy;
    bus.imem_resp_valid = do_rsp;
    bus.imem_resp_data = do_rsp ? instr_of(mem_q[0].addr) : 32'hDEAD_BEEF;
    bus.if_ready = ifr;
    bus.ex_redirect_valid = exv;
    bus.ex_redirect_target = ext;
    bus.pred_redirect_valid = pv;
    bus.pred_redirect_target = pt;
    #1;
    redir = exv || pv;
    want_req = !redir && (path_q.size() < D) && (mem_q.size() < D);
    last_addr = 32'h5555_5555;
    if (bus.imem_req_valid) last_addr = bus.imem_req_addr;
    if (bus.imem_req_valid && rdy) fires.push_back(bus.imem_req_addr);
    if (bus.if_valid && ifr) pops.push_back(bus.if_pc);
    check("req_valid", 32'(bus.imem_req_valid), 32'(want_req));
    if (want_req) check("req_addr", bus.imem_req_addr, exp_pc);
    check("if_valid", 32'(bus.if_valid), 32'(filled > 0));
    if (filled > 0) begin
      check("if_pc", bus.if_pc, path_q[0]);
      check("if_instr", bus.if_instr, instr_of(path_q[0]));
    end
    fire = want_req && rdy;
    pop = (filled > 0) && ifr;
    if (do_rsp) begin
      r = mem_q.pop_front();
      if (r.ep == epoch) filled++;
    end
    if (pop) begin
      void'(path_q.pop_front());
      filled--;
    end
    if (redir) begin
      tgt = exv ? ext : pt;
      epoch++;
      path_q.delete();
      filled = 0;
      exp_pc = {tgt[31:2], 2'b00};
    end else if (fire) begin
      mem_q.push_back('{exp_pc, epoch});
      path_q.push_back(exp_pc);
      exp_pc += 32'd4;
    end
    if (do_rsp) assert (mem_q.size() <= D);
  endtask
  initial begin
    vecs[0] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0000_0200};
    vecs[1] = '{1'b1, 32'h0000_0206, 1'b0, 32'h0000_0000, 32'h0000_0204};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0300, 32'h0000_0300};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0403, 32'h0000_0400};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[5] = '{1'b1, 32'h0000_0011, 1'b1, 32'h0000_0022, 32'h0000_0010};
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 0);
    check("t1_pop_count", 32'(pops.size()), 32'd8);
    for (int k = 0; k < pops.size() && k < 8; k++) check("t1_pop_pc", pops[k], 32'(4 * k));
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);
    check("t2_fire_count", 32'(fires.size()), 32'd4);
    check("t2_full_stall", 32'(bus.imem_req_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < pops.size() && k < 4; k++) check("t2_drain_pc", pops[k], 32'(4 * k));
    if (fires.size() > 4) check("t2_resume_addr", fires[4], 32'h10);
    else check("t2_resume_count", 32'(fires.size()), 32'd5);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0, 0);
    check("t3_redir_no_req", 32'(bus.imem_req_valid), 32'h0);
    fires.delete();
    pops.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 0);
    if (fires.size() > 0) check("t3_first_addr", fires[0], 32'h100);
    else check("t3_fire_count", 32'(fires.size()), 32'd1);
    if (pops.size() > 0) check("t3_first_pop", pops[0], 32'h100);
    else check("t3_pop_count", 32'(pops.size()), 32'd1);
    do_reset();
    for (int v = 0; v < 6; v++) begin
      step(0, 0, 0, vecs[v].exv, vecs[v].ext, vecs[v].pv, vecs[v].pt);
      step(0, 0, 0, 0, 0, 0, 0);
      check("tbl_redir_addr", last_addr, vecs[v].exp);
    end
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("wrap_addr", last_addr, 32'h0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t6_pre_valid", 32'(bus.if_valid), 32'h1);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    check("t6_post_addr", last_addr, 32'h0);
    for (int i = 0; i < 3000; i++)
      step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 4 != 0,
           $urandom % 40 == 0, $urandom, $urandom % 30 == 0, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of decode and the branch predictor.
- Holds the PC and issues in-order instruction-memory requests.
- Buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from decode (predicted-taken branch/jump) and from execute (mispredict), flushing wrong-path work including in-flight memory responses.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 4, fetch queue slots (power of 2, >=2); also the bound on outstanding requests.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response valid; responses return strictly in request order.
- imem_resp_data  in  32  instruction word.
- pred_redirect_valid  in  1  decode predicted taken; refetch from target.
- pred_redirect_target  in  XLEN  predicted target.
- ex_redirect_valid  in  1  execute detected mispredict.
- ex_redirect_target  in  XLEN  corrected PC.
- if_valid  out  1  queue head holds a filled instruction.
- if_ready  in  1  decode accepts head.
- if_instr  out  32  head instruction.
- if_pc  out  XLEN  head PC.

Behaviour:
- Reset (async assert, deassert sync to clk): pc=RESET_PC; queue empty; drop_count=0; imem_req_valid=0; if_valid=0; if_instr=0; if_pc=0.
- Queue slot = {pc, instr, filled}. Three pointers: alloc (at request), fill (at response), head (at pop). Occupancy counter is 0..FQ_DEPTH.
- Request issue:
  - imem_req_valid=1 when occupancy < FQ_DEPTH and no redirect is active this cycle.
  - imem_req_addr=pc, with pc[1:0] always 0.
  - On valid&&ready: allocate slot at alloc with pc, filled=0; pc <= pc+4 (wraps modulo 2^XLEN).
  - While ready is low, addr holds stable. Only a redirect may withdraw a request.
- Response: if drop_count>0, discard the response and decrement drop_count. Otherwise write instr to the slot at fill, set filled=1, advance fill.
- Output:
  - if_valid = head slot filled.
  - if_instr/if_pc come combinationally from the head slot.
  - Pop on if_valid&&if_ready.
  - A response to the empty-head slot is visible on if_valid the next cycle: 1-cycle latency from resp to decode.
- Redirect (ex_redirect_valid has priority over pred_redirect_valid when both assert):
  - pc <= target with bits [1:0] forced to 0.
  - All slots flushed: occupancy=0, pointers reset equal.
  - drop_count <= number of allocated-but-unfilled slots, excluding any response accepted this same cycle.
  - imem_req_valid=0 in the redirect cycle. The first request to the target goes out the next cycle.
  - A pop coinciding with a redirect is still valid: decode consumed it.
- Simultaneous alloc, fill and pop in one cycle are all legal and update occupancy by (+alloc −pop).
- Full (occupancy==FQ_DEPTH): no new request. Requests resume the cycle after a pop.
- drop_count must never exceed FQ_DEPTH. A response while drop_count==0 with no unfilled slot is a protocol error; the bench asserts it never occurs.
- New requests may issue while drop_count>0, because ordering guarantees the stale responses return first.

Decomposition:
- Shared package (core_pkg): XLEN default, RESET_PC, INSTR_WIDTH=32, and a fetch_slot_t struct {pc, instr, filled}.
- One sub-module: fetch_queue (slot storage, alloc/fill/head pointers, occupancy, flush input).
- fetch_unit keeps the PC, the request handshake, redirect priority and drop_count.

Test Plan:
- Reset then imem_req_ready=1, responses 1 cycle later, if_ready=1 -> addrs 0x0,0x4,0x8...; if_pc 0x0,0x4,... with matching instrs; steady 1 instr/cycle after a 2-cycle fill.
- if_ready=0, ready=1, no responses stalled -> exactly 4 requests (0x0..0xC) then imem_req_valid=0; raising if_ready after fills -> drains in order, requests resume at 0x10.
- 3 requests in flight (0x0,0x4,0x8), ex_redirect to 0x100 -> next request addr 0x100; 3 stale responses dropped; first if_pc=0x100.
- ex_redirect 0x200 and pred_redirect 0x300 in the same cycle -> pc=0x200; target 0x206 -> fetch addr 0x204.
- pc=0xFFFF_FFFC -> next request 0x0000_0000.
- Async reset mid-stream with 2 responses pending -> outputs zero immediately; after release, first addr=RESET_PC; late responses while drop_count=0 are not issued by the bench model (memory also reset).
